// File: rtl/layer_normalizer.sv
// Multi-lane layer normalizer: tracks per-layer peak magnitude, commits a power-of-two
// alignment shift at each layer start, and streams shifted/saturated lanes through one register stage.
module layer_normalizer #(
  parameter int unsigned DATA_BITWIDTH   = 16,
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned TARGET_BITWIDTH = 8,
  parameter bit          SIGNED          = 1'b0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [1:0]                                state,
  input  logic [NUM_CHANNELS*DATA_BITWIDTH-1:0]     s_tdata,
  input  logic [NUM_CHANNELS-1:0]                   s_tkeep,
  input  logic                                      s_tvalid,
  output logic                                      s_tready,
  output logic [NUM_CHANNELS*TARGET_BITWIDTH-1:0]   m_tdata,
  output logic [NUM_CHANNELS-1:0]                   m_tkeep,
  output logic                                      m_tvalid,
  input  logic                                      m_tready,
  output logic [DATA_BITWIDTH-1:0]                  output_shift,
  output logic                                      output_shift_left,
  output logic [DATA_BITWIDTH-1:0]                  layer_max,
  output logic                                      shift_update
);

  localparam int unsigned D = DATA_BITWIDTH;
  localparam int unsigned N = NUM_CHANNELS;
  localparam int unsigned T = TARGET_BITWIDTH;
  // Wide enough for a full-range lane left-shifted by up to T-1 plus a sign bit
  localparam int unsigned W = D + T + 1;
  localparam int unsigned A = SIGNED ? T - 2 : T - 1;
  localparam logic [1:0]  PREAM = 2'b00;
  localparam logic [D-1:0] MOST_NEG = {1'b1, {(D - 1){1'b0}}};
  localparam logic [D-1:0] MAX_POS  = ~MOST_NEG;
  localparam logic signed [W-1:0] SAT_HI = SIGNED ? W'((64'd1 << (T - 1)) - 64'd1)
                                                  : W'((64'd1 << T) - 64'd1);
  localparam logic signed [W-1:0] SAT_LO = SIGNED ? ~SAT_HI : '0;

  logic                pream_q;
  logic [D-1:0]        run_max;
  logic [D-1:0]        beat_peak;
  logic [N*T-1:0]      lane_out;
  logic [D-1:0]        lane;
  logic [D-1:0]        mag;
  logic signed [W-1:0] ext;
  logic signed [W-1:0] scaled;
  logic [T-1:0]        sat;
  logic [D-1:0]        msb;
  logic [D-1:0]        new_shift;
  logic                new_left;
  logic                accept;
  logic                commit;

  assign s_tready = m_tready || !m_tvalid;
  assign accept   = s_tvalid && s_tready;
  assign commit   = (state == PREAM) && !pream_q;

  // Per-lane magnitude reduction and shift/saturate using the currently committed shift
  always_comb begin
    beat_peak = '0;
    lane_out  = '0;
    lane      = '0;
    mag       = '0;
    ext       = '0;
    scaled    = '0;
    sat       = '0;
    for (int i = 0; i < int'(N); i++) begin
      lane = s_tdata[i*D +: D];
      mag  = lane;
      if (SIGNED && lane[D-1]) mag = (lane == MOST_NEG) ? MAX_POS : -lane;
      if (!s_tkeep[i]) mag = '0;
      if (mag > beat_peak) beat_peak = mag;
      ext    = {{(W - D){SIGNED & lane[D-1]}}, lane};
      scaled = output_shift_left ? (ext <<< output_shift) : (ext >>> output_shift);
      if (scaled > SAT_HI)      sat = SAT_HI[T-1:0];
      else if (scaled < SAT_LO) sat = SAT_LO[T-1:0];
      else                      sat = scaled[T-1:0];
      lane_out[i*T +: T] = s_tkeep[i] ? sat : '0;
    end
  end

  // Align the running max's MSB to bit A of the target range
  always_comb begin
    msb       = '0;
    new_shift = '0;
    new_left  = 1'b0;
    for (int i = 0; i < int'(D); i++) begin
      if (run_max[i]) msb = D'(i);
    end
    if (run_max != '0) begin
      if (msb < D'(A)) begin
        new_left  = 1'b1;
        new_shift = D'(A) - msb;
      end else begin
        new_shift = msb - D'(A);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pream_q           <= 1'b0;
      run_max           <= '0;
      output_shift      <= '0;
      output_shift_left <= 1'b0;
      layer_max         <= '0;
      shift_update      <= 1'b0;
      m_tvalid          <= 1'b0;
      m_tdata           <= '0;
      m_tkeep           <= '0;
    end else begin
      pream_q      <= (state == PREAM);
      shift_update <= commit;
      if (commit) begin
        output_shift      <= new_shift;
        output_shift_left <= new_left;
        layer_max         <= run_max;
        run_max           <= accept ? beat_peak : '0;
      end else if (accept && (beat_peak > run_max)) begin
        run_max <= beat_peak;
      end
      if (s_tready) begin
        m_tvalid <= s_tvalid;
        if (s_tvalid) begin
          m_tdata <= lane_out;
          m_tkeep <= s_tkeep;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_normalizer.sv
// Bench for layer_normalizer: unsigned and signed instances driven in lockstep and
// compared every cycle against an integer-arithmetic reference model.
module tb_layer_normalizer;

  localparam int D  = 16;
  localparam int N  = 4;
  localparam int T  = 8;
  localparam int OW = 2 * (2 + N*T + N + 2*D + 2);
  localparam logic [1:0] ST_PREAM = 2'b00;
  localparam logic [1:0] ST_DATA  = 2'b01;
  localparam logic [1:0] ST_QUIET = 2'b10;
  localparam logic [OW-1:0] RST_OBS = {1'b1, {(OW/2 - 1){1'b0}}, 1'b1, {(OW/2 - 1){1'b0}}};

  typedef struct packed {
    logic [1:0]     st;
    logic [N*D-1:0] d;
    logic [N-1:0]   k;
    logic           v;
    logic           r;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state;
  logic [N*D-1:0] s_tdata;
  logic [N-1:0] s_tkeep;
  logic s_tvalid, m_tready;

  logic u_ready, u_valid, u_left, u_upd;
  logic [N*T-1:0] u_data;
  logic [N-1:0] u_keep;
  logic [D-1:0] u_shift, u_lmax;
  logic g_ready, g_valid, g_left, g_upd;
  logic [N*T-1:0] g_data;
  logic [N-1:0] g_keep;
  logic [D-1:0] g_shift, g_lmax;

  int total = 0;
  int bad = 0;

  longint         mr_run[2];
  longint         mr_shift[2];
  longint         mr_lmax[2];
  bit             mr_left[2];
  bit             mr_upd[2];
  logic [N*T-1:0] mr_data[2];
  bit             mr_valid = 1'b0;
  logic [N-1:0]   mr_keep = '0;
  bit             mr_prev_pream = 1'b0;

  layer_normalizer #(.DATA_BITWIDTH(D), .NUM_CHANNELS(N), .TARGET_BITWIDTH(T), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .state(state), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tvalid(s_tvalid), .s_tready(u_ready), .m_tdata(u_data), .m_tkeep(u_keep),
    .m_tvalid(u_valid), .m_tready(m_tready), .output_shift(u_shift),
    .output_shift_left(u_left), .layer_max(u_lmax), .shift_update(u_upd));

  layer_normalizer #(.DATA_BITWIDTH(D), .NUM_CHANNELS(N), .TARGET_BITWIDTH(T), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .state(state), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tvalid(s_tvalid), .s_tready(g_ready), .m_tdata(g_data), .m_tkeep(g_keep),
    .m_tvalid(g_valid), .m_tready(m_tready), .output_shift(g_shift),
    .output_shift_left(g_left), .layer_max(g_lmax), .shift_update(g_upd));

  always #5 clk = ~clk;

  function automatic longint lane_val(input logic [D-1:0] raw, input bit sg);
    if (sg && raw[D-1]) return longint'(raw) - (longint'(1) << D);
    return longint'(raw);
  endfunction

  function automatic longint lane_mag(input logic [D-1:0] raw, input bit sg);
    longint v = lane_val(raw, sg);
    if (v == -(longint'(1) << (D - 1))) return (longint'(1) << (D - 1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  task automatic derive(input longint mx, input bit sg, output longint sh, output bit lf);
    int a = sg ? T - 2 : T - 1;
    int p = -1;
    longint t = mx;
    while (t > 0) begin
      t = t / 2;
      p++;
    end
    sh = 0;
    lf = 1'b0;
    if (mx != 0) begin
      if (p < a) begin
        lf = 1'b1;
        sh = longint'(a - p);
      end else begin
        sh = longint'(p - a);
      end
    end
  endtask

  function automatic logic [T-1:0] scale(input logic [D-1:0] raw, input bit sg,
                                         input longint sh, input bit lf);
    longint v  = lane_val(raw, sg);
    longint r  = lf ? v * (longint'(1) << sh) : (v >>> sh);
    longint hi = sg ? (longint'(1) << (T - 1)) - 1 : (longint'(1) << T) - 1;
    longint lo = sg ? -(longint'(1) << (T - 1)) : 0;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return T'(r);
  endfunction

  task automatic model_update();
    bit sready, acc, commit, sg, lf;
    longint peak, sh;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mr_run[k] = 0; mr_shift[k] = 0; mr_lmax[k] = 0;
        mr_left[k] = 1'b0; mr_upd[k] = 1'b0; mr_data[k] = '0;
      end
      mr_valid = 1'b0;
      mr_keep = '0;
      mr_prev_pream = 1'b0;
      return;
    end
    sready = m_tready || !mr_valid;
    acc    = s_tvalid && sready;
    commit = (state == ST_PREAM) && !mr_prev_pream;
    for (int k = 0; k < 2; k++) begin
      sg = (k == 1);
      peak = 0;
      for (int l = 0; l < N; l++)
        if (s_tkeep[l] && lane_mag(s_tdata[l*D +: D], sg) > peak) peak = lane_mag(s_tdata[l*D +: D], sg);
      if (acc)
        for (int l = 0; l < N; l++)
          mr_data[k][l*T +: T] = s_tkeep[l] ? scale(s_tdata[l*D +: D], sg, mr_shift[k], mr_left[k]) : '0;
      if (commit) begin
        derive(mr_run[k], sg, sh, lf);
        mr_shift[k] = sh;
        mr_left[k]  = lf;
        mr_lmax[k]  = mr_run[k];
        mr_upd[k]   = 1'b1;
        mr_run[k]   = acc ? peak : 0;
      end else begin
        mr_upd[k] = 1'b0;
        if (acc && peak > mr_run[k]) mr_run[k] = peak;
      end
    end
    if (sready) begin
      mr_valid = s_tvalid;
      if (s_tvalid) mr_keep = s_tkeep;
    end
    mr_prev_pream = (state == ST_PREAM);
  endtask

  function automatic logic [OW-1:0] dut_obs();
    return {u_ready, u_valid, u_data, u_keep, u_shift, u_left, u_lmax, u_upd,
            g_ready, g_valid, g_data, g_keep, g_shift, g_left, g_lmax, g_upd};
  endfunction

  function automatic logic [OW-1:0] model_obs();
    logic r = m_tready || !mr_valid;
    return {r, mr_valid, mr_data[0], mr_keep, D'(mr_shift[0]), mr_left[0], D'(mr_lmax[0]), mr_upd[0],
            r, mr_valid, mr_data[1], mr_keep, D'(mr_shift[1]), mr_left[1], D'(mr_lmax[1]), mr_upd[1]};
  endfunction

  function automatic logic [N*D-1:0] beat4(input logic [D-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic stim_t mk(input logic [1:0] st, input logic [N*D-1:0] d,
                               input logic [N-1:0] k, input logic v, input logic r);
    stim_t s;
    s.st = st; s.d = d; s.k = k; s.v = v; s.r = r;
    return s;
  endfunction

  task automatic step(input logic [1:0] st, input logic [N*D-1:0] d, input logic [N-1:0] k,
                      input logic v, input logic mr, input logic r);
    state = st; s_tdata = d; s_tkeep = k; s_tvalid = v; m_tready = mr; rst = r;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(ST_DATA, beat4(16'h1234, 16'h5678, 16'h9abc, 16'hdef0), 4'hF, 1'b1, 1'b0, 1'b1);
      total++;
      if (dut_obs() !== RST_OBS) begin
        bad++;
        $display("FAIL reset_state got=%h exp=%h", dut_obs(), RST_OBS);
      end
    end
  endtask

  task automatic test_commit_right();
    stim_t seq[$];
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'h0100, 16'h0300, 16'h0200, 16'h0010), 4'hF, 1'b1, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'h0050, 16'h0000, 16'h02FF, 16'h0000), 4'hF, 1'b1, 1'b0));
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'h0300, 16'h0, 16'h0, 16'h0), 4'b0001, 1'b1, 1'b0));
    foreach (seq[i]) begin
      step(seq[i].st, seq[i].d, seq[i].k, seq[i].v, 1'b1, seq[i].r);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++;
        $display("FAIL commit_right step=%0d got=%h exp=%h", i, dut_obs(), model_obs());
      end
      if (i == 5) begin
        total++;
        if ({u_shift, u_left, u_lmax, u_upd, g_shift, g_left, g_lmax, g_upd} !==
            {16'd2, 1'b0, 16'h0300, 1'b1, 16'd3, 1'b0, 16'h0300, 1'b1}) begin
          bad++;
          $display("FAIL commit_right_shift got u=%0d/%b/%h g=%0d/%b/%h exp u=2/0/0300 g=3/0/0300",
                   u_shift, u_left, u_lmax, g_shift, g_left, g_lmax);
        end
      end
      if (i == 6) begin
        total++;
        if ({u_valid, u_data[7:0], g_data[7:0]} !== {1'b1, 8'hC0, 8'h60}) begin
          bad++;
          $display("FAIL commit_right_data got v=%b u=%h g=%h exp v=1 u=c0 g=60", u_valid, u_data[7:0], g_data[7:0]);
        end
      end
    end
  endtask

  task automatic test_shift_left();
    stim_t seq[$];
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'h0005, 16'h0, 16'h0, 16'h0), 4'hF, 1'b1, 1'b0));
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'h0005, 16'h0010, 16'h0, 16'h0), 4'b0011, 1'b1, 1'b0));
    foreach (seq[i]) begin
      step(seq[i].st, seq[i].d, seq[i].k, seq[i].v, 1'b1, seq[i].r);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++;
        $display("FAIL shift_left step=%0d got=%h exp=%h", i, dut_obs(), model_obs());
      end
      if (i == 4) begin
        total++;
        if ({u_shift, u_left, u_lmax, u_upd} !== {16'd5, 1'b1, 16'h0005, 1'b1}) begin
          bad++;
          $display("FAIL shift_left_commit got %0d/%b/%h/%b exp 5/1/0005/1", u_shift, u_left, u_lmax, u_upd);
        end
      end
      if (i == 5) begin
        total++;
        if ({u_data[15:0], u_keep, g_data[15:0]} !== {16'hFFA0, 4'b0011, 16'h7F50}) begin
          bad++;
          $display("FAIL shift_left_sat got u=%h k=%b g=%h exp u=ffa0 k=0011 g=7f50", u_data[15:0], u_keep, g_data[15:0]);
        end
      end
    end
  endtask

  task automatic test_empty_layer();
    stim_t seq[$];
    int pulses = 0;
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, '0, 4'hF, 1'b1, 1'b0));
    seq.push_back(mk(ST_DATA, '0, 4'hF, 1'b1, 1'b0));
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    for (int j = 0; j < 4; j++) seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, '0, '0, 1'b0, 1'b0));
    foreach (seq[i]) begin
      step(seq[i].st, seq[i].d, seq[i].k, seq[i].v, 1'b1, seq[i].r);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++;
        $display("FAIL empty_layer step=%0d got=%h exp=%h", i, dut_obs(), model_obs());
      end
      if (i == 5 || i == 9) begin
        total++;
        if ({u_shift, u_left, u_lmax, u_upd, g_shift, g_left, g_upd} !== {16'd0, 1'b0, 16'd0, 1'b1, 16'd0, 1'b0, 1'b1}) begin
          bad++;
          $display("FAIL empty_layer_commit step=%0d got u=%0d/%b/%h/%b exp 0/0/0000/1", i, u_shift, u_left, u_lmax, u_upd);
        end
      end
      if (i >= 9 && i <= 12) pulses += int'(u_upd);
      if (i == 13) begin
        total++;
        if (pulses !== 1) begin
          bad++;
          $display("FAIL empty_layer_pulses got=%0d exp=1", pulses);
        end
      end
    end
  endtask

  task automatic test_tkeep();
    stim_t seq[$];
    logic [N*D-1:0] b = beat4(16'hFFFF, 16'h0040, 16'h0020, 16'h0003);
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, b, 4'b1110, 1'b1, 1'b0));
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, b, 4'b1110, 1'b1, 1'b0));
    foreach (seq[i]) begin
      step(seq[i].st, seq[i].d, seq[i].k, seq[i].v, 1'b1, seq[i].r);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++;
        $display("FAIL tkeep step=%0d got=%h exp=%h", i, dut_obs(), model_obs());
      end
      if (i == 4) begin
        total++;
        if ({u_shift, u_left, u_lmax} !== {16'd1, 1'b1, 16'h0040}) begin
          bad++;
          $display("FAIL tkeep_commit got %0d/%b/%h exp 1/1/0040", u_shift, u_left, u_lmax);
        end
      end
      if (i == 5) begin
        total++;
        if ({u_data[15:0], u_keep} !== {16'h8000, 4'b1110}) begin
          bad++;
          $display("FAIL tkeep_data got %h/%b exp 8000/1110", u_data[15:0], u_keep);
        end
      end
    end
  endtask

  task automatic test_signed();
    stim_t seq[$];
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'hFE00, 16'h0100, 16'h0, 16'h0), 4'hF, 1'b1, 1'b0));
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'hFE00, 16'h7FFF, 16'h0, 16'h0), 4'b0011, 1'b1, 1'b0));
    foreach (seq[i]) begin
      step(seq[i].st, seq[i].d, seq[i].k, seq[i].v, 1'b1, seq[i].r);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++;
        $display("FAIL signed step=%0d got=%h exp=%h", i, dut_obs(), model_obs());
      end
      if (i == 4) begin
        total++;
        if ({g_shift, g_left, g_lmax} !== {16'd3, 1'b0, 16'h0200}) begin
          bad++;
          $display("FAIL signed_commit got %0d/%b/%h exp 3/0/0200", g_shift, g_left, g_lmax);
        end
      end
      if (i == 5) begin
        total++;
        if (g_data[15:0] !== 16'h7FC0) begin
          bad++;
          $display("FAIL signed_data got %h exp 7fc0", g_data[15:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N*T-1:0] exp_q[$];
    logic [N*T-1:0] e;
    logic [N*D-1:0] b;
    logic v, mr;
    int sent = 0;
    int delivered = 0;
    int nb = 12;
    step(ST_DATA, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 40; c++) begin
      mr = !((c % 7) >= 2 && (c % 7) <= 4);
      v  = (sent < nb);
      b  = beat4(D'(sent * 'h230 + 'h100), D'(sent * 3), 16'h8000, 16'h0001);
      if (u_valid && mr) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL backpressure_dup cyc=%0d got=%h exp=none", c, u_data);
        end else begin
          e = exp_q.pop_front();
          if (u_data !== e) begin
            bad++;
            $display("FAIL backpressure_data cyc=%0d got=%h exp=%h", c, u_data, e);
          end
        end
        delivered++;
      end
      if (v && (mr || !mr_valid)) begin
        for (int l = 0; l < N; l++) e[l*T +: T] = scale(b[l*D +: D], 1'b0, mr_shift[0], mr_left[0]);
        exp_q.push_back(e);
        sent++;
      end
      step(ST_DATA, b, 4'hF, v, mr, 1'b0);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, dut_obs(), model_obs());
      end
    end
    total++;
    if (delivered !== nb) begin
      bad++;
      $display("FAIL backpressure_count got=%0d exp=%0d", delivered, nb);
    end
  endtask

  task automatic test_reset_mid();
    stim_t seq[$];
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'h7000, 16'h0, 16'h0, 16'h0), 4'hF, 1'b1, 1'b0));
    seq.push_back(mk(ST_DATA, beat4(16'h6000, 16'h0, 16'h0, 16'h0), 4'hF, 1'b1, 1'b1));
    seq.push_back(mk(ST_DATA, beat4(16'h0020, 16'h0010, 16'h0, 16'h0), 4'hF, 1'b1, 1'b0));
    seq.push_back(mk(ST_QUIET, '0, '0, 1'b0, 1'b0));
    seq.push_back(mk(ST_PREAM, '0, '0, 1'b0, 1'b0));
    foreach (seq[i]) begin
      step(seq[i].st, seq[i].d, seq[i].k, seq[i].v, 1'b1, seq[i].r);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++;
        $display("FAIL reset_mid step=%0d got=%h exp=%h", i, dut_obs(), model_obs());
      end
      if (i == 3) begin
        total++;
        if (dut_obs() !== RST_OBS) begin
          bad++;
          $display("FAIL reset_mid_clear got=%h exp=%h", dut_obs(), RST_OBS);
        end
      end
      if (i == 6) begin
        total++;
        if ({u_shift, u_left, u_lmax, u_upd} !== {16'd2, 1'b1, 16'h0020, 1'b1}) begin
          bad++;
          $display("FAIL reset_mid_commit got %0d/%b/%h/%b exp 2/1/0020/1", u_shift, u_left, u_lmax, u_upd);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] st = ST_DATA;
    logic [N*D-1:0] d;
    logic [D-1:0] lane;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) st = 2'($urandom_range(0, 3));
      for (int l = 0; l < N; l++) begin
        lane = D'($urandom);
        lane = lane >> $urandom_range(0, 15);
        if ($urandom_range(0, 20) == 0) lane = 16'h8000;
        d[l*D +: D] = lane;
      end
      step(st, d, 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) == 0);
      total++;
      if (dut_obs() !== model_obs()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_obs(), model_obs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_commit_right();
    test_shift_left();
    test_empty_layer();
    test_tkeep();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_normalizer.md
# layer_normalizer

Multi-channel successor to the single-lane normalization block. It does three things across NUM_CHANNELS parallel lanes:
- tracks the peak magnitude of every accepted beat in a layer;
- at the next layer start, derives a power-of-two shift that aligns that peak's MSB to the top of a TARGET_BITWIDTH range;
- applies the committed shift, with saturation, to the streaming data through a one-stage registered, back-pressurable pipeline.

It sits between the photonic readout datapath and the next layer's integer input buffer.

## Interface
- DATA_BITWIDTH, 16, width of each input lane
- NUM_CHANNELS, 4, number of parallel lanes per beat
- TARGET_BITWIDTH, 8, width of each output lane (must be ≤ DATA_BITWIDTH, ≥ 2)
- SIGNED, 0, 0 = lanes are unsigned; 1 = lanes are two's complement
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- state  in  2  layer state: 00 PREAM, 01 DATA, 10 QUIET, 11 FINAL
- s_tdata  in  NUM_CHANNELS*DATA_BITWIDTH  input lanes, lane 0 in LSBs
- s_tkeep  in  NUM_CHANNELS  per-lane enable; lanes with 0 are excluded from stats and output as 0
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input accepted when s_tvalid && s_tready
- m_tdata  out  NUM_CHANNELS*TARGET_BITWIDTH  shifted, saturated lanes
- m_tkeep  out  NUM_CHANNELS  registered copy of s_tkeep
- m_tvalid  out  1  output beat valid
- m_tready  in  1  downstream ready
- output_shift  out  DATA_BITWIDTH  committed shift amount
- output_shift_left  out  1  1 = left shift, 0 = right shift
- layer_max  out  DATA_BITWIDTH  peak magnitude captured at the last commit
- shift_update  out  1  one-cycle pulse on each commit

## Operation
- **Accept:** a beat is accepted when s_tvalid && s_tready.
- **s_tready:** equals m_tready || !m_tvalid.
- **Lane magnitude:**
  - SIGNED=0: raw value.
  - SIGNED=1: absolute value; the most-negative code maps to 2^(DATA_BITWIDTH-1)-1.
  - Lanes with tkeep=0 count as magnitude 0.
- **Beat peak:** maximum lane magnitude of an accepted beat.
- **Running max:** updated in every state with the beat peak when that peak exceeds the running max.
- **Commit (first PREAM cycle, i.e. state==PREAM and the previous cycle's state != PREAM, or the first PREAM cycle after reset):**
  - output_shift and output_shift_left are loaded from the pre-commit running max.
  - layer_max is loaded with the same value.
  - shift_update pulses.
  - The running max is loaded with that cycle's beat peak if a beat is accepted, else 0.
  - Further PREAM cycles do not commit again; they accumulate normally.
- **Shift derivation:**
  - A = TARGET_BITWIDTH-1 when SIGNED=0, else TARGET_BITWIDTH-2.
  - p = index of the highest set bit of the max.
  - If p < A: left = 1, shift = A-p.
  - Otherwise: left = 0, shift = p-A.
  - If max == 0: shift = 0, left = 0.
- **Datapath:**
  - Each kept lane is shifted by the committed shift: left shift, or right shift (arithmetic when SIGNED=1, truncating toward -inf).
  - The result is computed at full width without overflow, then saturated to [0, 2^T-1] (unsigned) or [-2^(T-1), 2^(T-1)-1] (signed).
  - The shift used is the one committed before the beat's accept cycle.
- **Reset:**
  - Every output is 0: m_tvalid, m_tdata, m_tkeep, output_shift, output_shift_left, layer_max, shift_update.
  - s_tready is 1 after reset, since m_tvalid=0.
  - Running max is cleared.
  - Reset mid-layer discards the partial max and any held output beat.

## Timing
- **Latency:** data latency is 1 cycle from accept to m_tvalid; the registered output holds stable while m_tvalid && !m_tready.
- **Full throughput:** with m_tready held high, the block sustains 1 beat/cycle.
- **Commit timing:** shift outputs change on the clock edge that ends the first PREAM cycle.
- **Shift applied to beats:**
  - A beat accepted in that first PREAM cycle uses the old shift.
  - Beats accepted from the next cycle onward use the new shift.
- **Simultaneous events:** when a commit and an accept occur in the same cycle, the beat goes into the new layer's max, not the committed one.
- **Max tracking latency:** compare-and-update is single-cycle (combinational lane reduction plus one register).

## Test plan
- D=16, T=8, N=4, unsigned: layer beats peaking at 0x0300, then PREAM → output_shift=2, left=0, layer_max=0x0300; next beat 0x0300 → m_tdata lane 0x C0.
- Peak 0x0005 → shift=5, left=1; then lane 0x0005 → 0xA0; lane 0x0010 → saturates to 0xFF.
- Layer with no accepted beats, or all zeros → shift=0, left=0, shift_update still pulses once; PREAM held 4 cycles → exactly one pulse.
- tkeep=4'b1110 with lane0=0xFFFF, others ≤0x0040 → committed shift derived from 0x0040 (left=1, shift=1); m_tdata lane0=0.
- SIGNED=1: peak -0x0200 → A=6, p=9, right shift 3; lane -0x0200 → -0x40 (0xC0); lane 0x7FFF → 0x7F.
- Backpressure: m_tready low 3 cycles with s_tvalid high → m_tdata stable, s_tready low, no beat lost or duplicated; rst asserted mid-layer → all outputs 0 the next cycle, and the following commit reflects only post-reset beats.
